// File: rtl/screen_fb_arbiter.sv
// Framebuffer arbiter: one single-port RAM shared by a display reader, two writers
// and a clear engine. A writer that has waited too long takes priority over the display.
module screen_fb_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_btn,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_ack,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_ack,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clrState_t;
  typedef enum logic [2:0] {G_NONE, G_DISP, G_WR0, G_WR1, G_CLR} grant_t;

  clrState_t         state, stateNext;
  grant_t            grant;
  logic [ADDR_W-1:0] clrAddr;
  logic [DATA_W-1:0] clrValue;
  logic [CNT_W-1:0]  cnt0, cnt1;
  logic              rrPtr;
  logic              elig0, elig1, starve0, starve1;

  // A writer still seeing its ack is ineligible: its req has not had a chance to fall yet.
  always_comb begin
    elig0   = wr0_req && !wr0_ack && (state != CLEAR);
    elig1   = wr1_req && !wr1_ack && (state != CLEAR);
    starve0 = elig0 && (cnt0 == CNT_MAX);
    starve1 = elig1 && (cnt1 == CNT_MAX);
    grant   = G_NONE;
    if (starve0 && starve1)      grant = rrPtr ? G_WR1 : G_WR0;
    else if (starve0)            grant = G_WR0;
    else if (starve1)            grant = G_WR1;
    else if (disp_req)           grant = G_DISP;
    else if (elig0 && elig1)     grant = rrPtr ? G_WR1 : G_WR0;
    else if (elig0)              grant = G_WR0;
    else if (elig1)              grant = G_WR1;
    else if (state == CLEAR)     grant = G_CLR;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (clr_start) stateNext = CLEAR;
      CLEAR:   if (grant == G_CLR && clrAddr == '1) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign clr_busy  = (state == CLEAR);
  assign clr_done  = (state == DONE);
  assign disp_data = disp_valid ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst_btn) begin
    if (rst_btn) begin
      state      <= IDLE;
      clrAddr    <= '0;
      clrValue   <= '0;
      cnt0       <= '0;
      cnt1       <= '0;
      rrPtr      <= 1'b0;
      disp_ack   <= 1'b0;
      disp_valid <= 1'b0;
      wr0_ack    <= 1'b0;
      wr1_ack    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= stateNext;
      mem_en     <= (grant != G_NONE);
      mem_we     <= (grant == G_WR0) || (grant == G_WR1) || (grant == G_CLR);
      disp_ack   <= (grant == G_DISP);
      wr0_ack    <= (grant == G_WR0);
      wr1_ack    <= (grant == G_WR1);
      disp_valid <= disp_ack;

      case (grant)
        G_DISP: mem_addr <= disp_addr;
        G_WR0: begin
          mem_addr  <= wr0_addr;
          mem_wdata <= wr0_data;
          rrPtr     <= 1'b1;
        end
        G_WR1: begin
          mem_addr  <= wr1_addr;
          mem_wdata <= wr1_data;
          rrPtr     <= 1'b0;
        end
        G_CLR: begin
          mem_addr  <= clrAddr;
          mem_wdata <= clrValue;
          clrAddr   <= clrAddr + ADDR_W'(1);
        end
        default: ;
      endcase

      if (state == IDLE && clr_start) begin
        clrValue <= clr_value;
        clrAddr  <= '0;
      end

      if (state == CLEAR || !wr0_req || grant == G_WR0) cnt0 <= '0;
      else if (cnt0 != CNT_MAX)                          cnt0 <= cnt0 + CNT_W'(1);
      if (state == CLEAR || !wr1_req || grant == G_WR1) cnt1 <= '0;
      else if (cnt1 != CNT_MAX)                          cnt1 <= cnt1 + CNT_W'(1);
    end
  end

endmodule
